inst_field_decode: RTL and testbench
====================================

// Module: inst_field_decode
// PURPOSE
//  Parametrised, pipelined RISC-V field splitter / immediate generator for all base formats
//  (R/I/S/B/U/J). Sits between fetch and rename/dispatch in the decode stage.
//  Accepts one 32-bit instruction plus PC per cycle over valid/ready.
//  Emits register fields, funct codes, a format tag, an XLEN-sign-extended immediate and an illegal flag.
//  One registered output stage, plus a skid entry so in_ready is a pure register output.
// PARAMETERS
//  XLEN  32  datapath width of pc/imm; legal values 32 or 64
//  SKID  1   1: 2-entry (output + skid), in_ready registered; 0: 1-entry, in_ready = out_ready | ~out_valid
// PORTS
//  clk         in   1     clock, all state on rising edge
//  rst         in   1     asynchronous, active-high reset
//  flush       in   1     synchronous; discard all held and incoming instructions
//  in_valid    in   1     upstream instruction valid
//  in_ready    out  1     block can accept this cycle
//  in_instr    in   32    raw instruction
//  in_pc       in   XLEN  instruction PC
//  out_valid   out  1     decoded bundle valid
//  out_ready   in   1     downstream accepts bundle
//  out_pc      out  XLEN  PC of bundle
//  out_opcode  out  7     instr[6:0]
//  out_rd      out  5     instr[11:7]
//  out_func3   out  3     instr[14:12]
//  out_rs1     out  5     instr[19:15]
//  out_rs2     out  5     instr[24:20]
//  out_func7   out  7     instr[31:25]
//  out_fmt     out  3     0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
//  out_imm     out  XLEN  sign-extended immediate per out_fmt; 0 for R and illegal
//  out_illegal out  1     unknown opcode or instr[1:0] != 2'b11
// BEHAVIOUR
//  - Reset: out_valid=0, skid empty, all out_* data = 0, in_ready=1 (during and after reset).
//  - Opcode map: 0110111/0010111 -> U; 1101111 -> J; 1100111/0000011/0010011/1110011/0001111 -> I;
//    1100011 -> B; 0100011 -> S; 0110011 -> R; anything else -> fmt 7, illegal=1.
//  - Imm: I = {instr[31:20]}; S = {instr[31:25],instr[11:7]}; B = {instr[31],instr[7],instr[30:25],instr[11:8],0};
//    J = {instr[31],instr[19:12],instr[20],instr[30:21],0}.
//  - I/S/B/J immediates sign-extended from instr[31] to XLEN.
//  - U immediate = {instr[31:12],12'b0}, sign-extended to XLEN (XLEN=64 upper 32 = instr[31]).
//  - Raw fields (rd/rs1/rs2/func3/func7) are always passed, regardless of format.
//  - Decode is combinational on the in_* side; held state is decoded bundles. Latency 1 cycle, in to out.
//  - Transfer happens when valid & ready on that interface, same edge.
//  - out_* data stays stable while out_valid & ~out_ready.
//  - SKID=1, in_ready = ~skid_valid:
//    - accepted while out empty or draining -> load out stage;
//    - accepted while out stalled -> load skid;
//    - out drains with skid full -> out <= skid, skid empties, in_ready=1 next cycle.
//  - Full: out & skid both valid -> in_ready=0; no accept, no overwrite.
//  - Order is strictly FIFO. Simultaneous drain + accept with skid full cannot occur, since in_ready=0.
//  - flush=1: out_valid=0 and skid empty next cycle; in-cycle input dropped even if in_valid&in_ready;
//    flush wins over all other events. in_ready=1 cycle after flush.
//  - rst asserted mid-stream: all held bundles lost immediately, outputs return to reset values asynchronously.
// TESTING
//  1. 0xFFF10093 (addi x1,x2,-1), out_ready=1 -> next cycle fmt=1, rd=1, rs1=2, imm=0xFFFFFFFF, illegal=0.
//  2. 0x00532423 (sw) -> fmt=2, rs1=6, rs2=5, imm=8; 0xFE000EE3 (beq -4) -> fmt=3, imm=0xFFFFFFFC.
//  3. XLEN=64: 0x80000037 (lui) -> imm=0xFFFFFFFF80000000, rd=0, fmt=4.
//  4. Hold out_ready=0, stream 3 instrs -> 2 accepted, in_ready=0 from cycle 2.
//     Release -> emitted in order, 1/cycle, no drop, no duplication.
//  5. Instr 0x00000000 and 0x0000007F -> fmt=7, illegal=1, imm=0.
//  6. Flush with out+skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1,
//     flushed bundles never emitted. Repeat with rst mid-stream.

Source files
------------

// File: rtl/inst_field_decode_if.sv
// Instruction-in / decoded-bundle-out handshake bundle for inst_field_decode.
// The master drives instructions and consumes bundles; the slave is the decoder.
interface inst_field_decode_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [2:0]      out_func3;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [6:0]      out_func7;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_func3,
           out_rs1, out_rs2, out_func7, out_fmt, out_imm, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_func3,
           out_rs1, out_rs2, out_func7, out_fmt, out_imm, out_illegal
  );
endinterface

// File: rtl/inst_field_decode.sv
// RISC-V base-format field splitter and immediate generator with one output
// register stage and an optional skid entry so in_ready comes straight from a flop.
module inst_field_decode #(
  parameter int XLEN = 32,
  parameter bit SKID = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  inst_field_decode_if.slave bus
);
  localparam logic [2:0] fmt_r   = 3'd0;
  localparam logic [2:0] fmt_i   = 3'd1;
  localparam logic [2:0] fmt_s   = 3'd2;
  localparam logic [2:0] fmt_b   = 3'd3;
  localparam logic [2:0] fmt_u   = 3'd4;
  localparam logic [2:0] fmt_j   = 3'd5;
  localparam logic [2:0] fmt_bad = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } bundle_t;

  // Bit 0 = output stage occupied, bit 1 = skid occupied, so both flags are plain flops.
  typedef enum logic [1:0] {
    s_empty = 2'b00,
    s_one   = 2'b01,
    s_two   = 2'b11
  } occ_t;

  function automatic bundle_t decode(input logic [31:0] instr, input logic [XLEN-1:0] pc);
    bundle_t            b;
    logic signed [31:0] imm32;
    b       = '0;
    b.pc    = pc;
    b.instr = instr;
    imm32   = '0;
    case (instr[6:0])
      7'b0110111, 7'b0010111:                         b.fmt = fmt_u;
      7'b1101111:                                     b.fmt = fmt_j;
      7'b1100111, 7'b0000011, 7'b0010011,
      7'b1110011, 7'b0001111:                         b.fmt = fmt_i;
      7'b1100011:                                     b.fmt = fmt_b;
      7'b0100011:                                     b.fmt = fmt_s;
      7'b0110011:                                     b.fmt = fmt_r;
      default:                                        b.fmt = fmt_bad;
    endcase
    case (b.fmt)
      fmt_i:   imm32 = {{20{instr[31]}}, instr[31:20]};
      fmt_s:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      fmt_b:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      fmt_u:   imm32 = {instr[31:12], 12'b0};
      fmt_j:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    // Signed size cast replicates bit 31 into the upper half when XLEN=64.
    b.imm     = XLEN'(imm32);
    b.illegal = (b.fmt == fmt_bad);
    return b;
  endfunction

  occ_t    state_reg, state_next;
  bundle_t out_reg, out_next;
  bundle_t skid_reg, skid_next;
  bundle_t in_bundle;
  logic    accept;

  assign in_bundle = decode(bus.in_instr, bus.in_pc);
  assign accept    = bus.in_valid & bus.in_ready & ~bus.flush;

  generate
    if (SKID) begin : g_skid
      assign bus.in_ready = ~state_reg[1];
    end else begin : g_noskid
      assign bus.in_ready = bus.out_ready | ~state_reg[0];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
    skid_next  = skid_reg;
    if (bus.flush) begin
      state_next = s_empty;
    end else begin
      case (state_reg)
        s_empty: begin
          if (accept) begin
            out_next   = in_bundle;
            state_next = s_one;
          end
        end
        s_one: begin
          if (bus.out_ready) begin
            if (accept) out_next = in_bundle;
            else        state_next = s_empty;
          end else if (accept && SKID) begin
            skid_next  = in_bundle;
            state_next = s_two;
          end
        end
        s_two: begin
          if (bus.out_ready) begin
            out_next   = skid_reg;
            state_next = s_one;
          end
        end
        default: state_next = s_empty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= s_empty;
      out_reg   <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      skid_reg  <= skid_next;
    end
  end

  assign bus.out_valid   = state_reg[0];
  assign bus.out_pc      = out_reg.pc;
  assign bus.out_opcode  = out_reg.instr[6:0];
  assign bus.out_rd      = out_reg.instr[11:7];
  assign bus.out_func3   = out_reg.instr[14:12];
  assign bus.out_rs1     = out_reg.instr[19:15];
  assign bus.out_rs2     = out_reg.instr[24:20];
  assign bus.out_func7   = out_reg.instr[31:25];
  assign bus.out_fmt     = out_reg.fmt;
  assign bus.out_imm     = out_reg.imm;
  assign bus.out_illegal = out_reg.illegal;
endmodule

// File: tb/tb_inst_field_decode.sv
// Directed bench for inst_field_decode: field/immediate table, backpressure,
// flush and asynchronous reset on an XLEN=32 instance, plus XLEN=64 immediates.
module tb_inst_field_decode;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  inst_field_decode_if #(.XLEN(32)) i32 ();
  inst_field_decode_if #(.XLEN(64)) i64 ();

  inst_field_decode #(.XLEN(32), .SKID(1'b1)) dut32 (.clk(clk), .rst(rst), .bus(i32));
  inst_field_decode #(.XLEN(64), .SKID(1'b1)) dut64 (.clk(clk), .rst(rst), .bus(i64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send32(input logic [31:0] instr, input logic [31:0] pc);
    i32.in_valid = 1'b1;
    i32.in_instr = instr;
    i32.in_pc    = pc;
    step();
    i32.in_valid = 1'b0;
  endtask

  task automatic send64(input logic [31:0] instr, input logic [63:0] pc);
    i64.in_valid = 1'b1;
    i64.in_instr = instr;
    i64.in_pc    = pc;
    step();
    i64.in_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0]  = '{32'hFFF10093, 3'd1, 32'hFFFFFFFF, 5'd1,  5'd2,  5'd31, 3'd0, 7'h7F};
    vecs[1]  = '{32'h00532423, 3'd2, 32'h00000008, 5'd8,  5'd6,  5'd5,  3'd2, 7'h00};
    vecs[2]  = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 5'd29, 5'd0,  5'd0,  3'd0, 7'h7F};
    vecs[3]  = '{32'h00000000, 3'd7, 32'h00000000, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00};
    vecs[4]  = '{32'h0000007F, 3'd7, 32'h00000000, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00};
    vecs[5]  = '{32'h00B50533, 3'd0, 32'h00000000, 5'd10, 5'd10, 5'd11, 3'd0, 7'h00};
    vecs[6]  = '{32'h12345297, 3'd4, 32'h12345000, 5'd5,  5'd8,  5'd3,  3'd5, 7'h09};
    vecs[7]  = '{32'hFF9FF0EF, 3'd5, 32'hFFFFFFF8, 5'd1,  5'd31, 5'd25, 3'd7, 7'h7F};
    vecs[8]  = '{32'h7FF0A183, 3'd1, 32'h000007FF, 5'd3,  5'd1,  5'd31, 3'd2, 7'h3F};
    vecs[9]  = '{32'h00208463, 3'd3, 32'h00000008, 5'd8,  5'd1,  5'd2,  3'd0, 7'h00};
    vecs[10] = '{32'h00000011, 3'd7, 32'h00000000, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00};
    vecs[11] = '{32'h00100073, 3'd1, 32'h00000001, 5'd0,  5'd0,  5'd1,  3'd0, 7'h00};
    vecs[12] = '{32'h0000000F, 3'd1, 32'h00000000, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00};
    vecs[13] = '{32'h80000037, 3'd4, 32'h80000000, 5'd0,  5'd0,  5'd0,  3'd0, 7'h40};

    rst = 1'b1;
    i32.flush = 1'b0; i32.in_valid = 1'b0; i32.in_instr = '0; i32.in_pc = '0; i32.out_ready = 1'b0;
    i64.flush = 1'b0; i64.in_valid = 1'b0; i64.in_instr = '0; i64.in_pc = '0; i64.out_ready = 1'b0;
    #1;
    check("rst_valid", i32.out_valid, 0);
    check("rst_ready", i32.in_ready, 1);
    check("rst_imm", i32.out_imm, 0);
    check("rst_pc", i32.out_pc, 0);
    repeat (2) step();
    rst = 1'b0;
    step();
    check("post_rst_ready", i32.in_ready, 1);
    check("post_rst_valid", i32.out_valid, 0);

    // Decode table, one instruction at a time with downstream always ready.
    i32.out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      logic [31:0] pc;
      logic [31:0] ins;
      pc  = 32'h1000 + 32'(i) * 4;
      ins = vecs[i].instr;
      send32(ins, pc);
      $display("vec %0d instr=%h fmt=%0d imm=%h", i, ins, i32.out_fmt, i32.out_imm);
      check("vec_valid", i32.out_valid, 1);
      check("vec_pc", i32.out_pc, pc);
      check("vec_opcode", i32.out_opcode, ins[6:0]);
      check("vec_fmt", i32.out_fmt, vecs[i].fmt);
      check("vec_imm", i32.out_imm, vecs[i].imm);
      check("vec_illegal", i32.out_illegal, (vecs[i].fmt == 3'd7) ? 1 : 0);
      check("vec_rd", i32.out_rd, vecs[i].rd);
      check("vec_rs1", i32.out_rs1, vecs[i].rs1);
      check("vec_rs2", i32.out_rs2, vecs[i].rs2);
      check("vec_f3", i32.out_func3, vecs[i].f3);
      check("vec_f7", i32.out_func7, vecs[i].f7);
    end
    step();
    check("drain_empty", i32.out_valid, 0);

    // Backpressure: three offered while stalled, two held, released in order.
    i32.out_ready = 1'b0;
    i32.in_valid  = 1'b1;
    i32.in_instr  = 32'hFFF10093; i32.in_pc = 32'h2000;
    check("bp_ready0", i32.in_ready, 1);
    step();
    check("bp_ready1", i32.in_ready, 1);
    i32.in_instr = 32'h00532423; i32.in_pc = 32'h2004;
    step();
    check("bp_ready2", i32.in_ready, 0);
    check("bp_head_pc", i32.out_pc, 32'h2000);
    i32.in_instr = 32'hFE000EE3; i32.in_pc = 32'h2008;
    step();
    $display("bp stalled out_pc=%h in_ready=%0d", i32.out_pc, i32.in_ready);
    check("bp_full_ready", i32.in_ready, 0);
    check("bp_hold_pc", i32.out_pc, 32'h2000);
    check("bp_hold_imm", i32.out_imm, 32'hFFFFFFFF);
    check("bp_hold_valid", i32.out_valid, 1);
    i32.out_ready = 1'b1;
    step();
    check("bp_out2_pc", i32.out_pc, 32'h2004);
    check("bp_out2_imm", i32.out_imm, 32'h8);
    check("bp_out2_ready", i32.in_ready, 1);
    step();
    i32.in_valid = 1'b0;
    check("bp_out3_pc", i32.out_pc, 32'h2008);
    check("bp_out3_imm", i32.out_imm, 32'hFFFFFFFC);
    check("bp_out3_valid", i32.out_valid, 1);
    step();
    check("bp_done", i32.out_valid, 0);

    // Flush with both entries full and an input offered.
    i32.out_ready = 1'b0;
    send32(32'hFFF10093, 32'h3000);
    send32(32'h00532423, 32'h3004);
    check("fl_full", i32.in_ready, 0);
    i32.in_valid = 1'b1; i32.in_instr = 32'hFE000EE3; i32.in_pc = 32'h3008;
    i32.flush = 1'b1;
    step();
    i32.flush = 1'b0; i32.in_valid = 1'b0;
    $display("flush full out_valid=%0d in_ready=%0d", i32.out_valid, i32.in_ready);
    check("fl_valid", i32.out_valid, 0);
    check("fl_ready", i32.in_ready, 1);
    i32.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("fl_no_emit", i32.out_valid, 0);
    end
    // Flush while empty must drop an input that would otherwise be accepted.
    i32.in_valid = 1'b1; i32.in_instr = 32'h00B50533; i32.in_pc = 32'h300C;
    i32.flush = 1'b1;
    step();
    i32.flush = 1'b0; i32.in_valid = 1'b0;
    check("fl_drop_in", i32.out_valid, 0);
    send32(32'h7FF0A183, 32'h3010);
    check("fl_after_pc", i32.out_pc, 32'h3010);
    check("fl_after_imm", i32.out_imm, 32'h7FF);
    step();

    // Asynchronous reset mid-stream with both entries full.
    i32.out_ready = 1'b0;
    send32(32'hFFF10093, 32'h4000);
    i32.in_valid = 1'b1; i32.in_instr = 32'h00532423; i32.in_pc = 32'h4004;
    step();
    check("rs_full", i32.in_ready, 0);
    #3 rst = 1'b1;
    #1;
    $display("async rst out_valid=%0d in_ready=%0d", i32.out_valid, i32.in_ready);
    check("rs_valid", i32.out_valid, 0);
    check("rs_ready", i32.in_ready, 1);
    check("rs_pc", i32.out_pc, 0);
    check("rs_imm", i32.out_imm, 0);
    check("rs_rd", i32.out_rd, 0);
    step();
    rst = 1'b0; i32.in_valid = 1'b0; i32.out_ready = 1'b1;
    step();
    check("rs_no_emit", i32.out_valid, 0);
    send32(32'hFF9FF0EF, 32'h4010);
    check("rs_after_pc", i32.out_pc, 32'h4010);
    check("rs_after_fmt", i32.out_fmt, 5);

    // XLEN=64 sign extension.
    i64.out_ready = 1'b1;
    send64(32'h80000037, 64'h1_0000_0000);
    $display("x64 lui imm=%h", i64.out_imm);
    check("x64_lui_imm", i64.out_imm, 64'hFFFFFFFF80000000);
    check("x64_lui_rd", i64.out_rd, 0);
    check("x64_lui_fmt", i64.out_fmt, 4);
    check("x64_lui_pc", i64.out_pc, 64'h1_0000_0000);
    send64(32'hFFF10093, 64'h1_0000_0004);
    check("x64_addi_imm", i64.out_imm, 64'hFFFFFFFFFFFFFFFF);
    send64(32'h12345297, 64'h1_0000_0008);
    check("x64_auipc_imm", i64.out_imm, 64'h0000000012345000);
    send64(32'hFE000EE3, 64'h1_0000_000C);
    check("x64_beq_imm", i64.out_imm, 64'hFFFFFFFFFFFFFFFC);
    step();
    check("x64_done", i64.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
